// File: rtl/addsub_rr_scheduler_pkg.sv
// Shared constants for the add/sub scheduler: FSM state encodings, opcode values
// and the round-robin pointer wrap helper.
package addsub_rr_scheduler_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  // Index of the requester that gets first priority after idx has been served.
  function automatic int wrap_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/addsub_rr_scheduler_csa.sv
// Carry-select adder/subtractor: the low half ripples, and the high half is
// precomputed for both carry-in values and then selected by the low carry.
module carry_select_adder_subtractor
  import addsub_rr_scheduler_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int LO = WIDTH / 2;
  localparam int HI = WIDTH - LO;

  logic [WIDTH-1:0] bx;
  logic             cin;
  logic [LO:0]      lo_sum;
  logic [HI:0]      hi0;
  logic [HI:0]      hi1;
  logic [HI-1:0]    hi_sel;
  logic             c_out;

  // Subtraction is a + ~b + 1; the final carry is inverted to report a borrow.
  assign bx  = (op == OP_SUB) ? ~b : b;
  assign cin = (op == OP_SUB);

  assign lo_sum = {1'b0, a[LO-1:0]} + {1'b0, bx[LO-1:0]} + {{LO{1'b0}}, cin};
  assign hi0    = {1'b0, a[WIDTH-1:LO]} + {1'b0, bx[WIDTH-1:LO]};
  assign hi1    = {1'b0, a[WIDTH-1:LO]} + {1'b0, bx[WIDTH-1:LO]} + {{HI{1'b0}}, 1'b1};

  assign {c_out, hi_sel} = lo_sum[LO] ? hi1 : hi0;
  assign result = {hi_sel, lo_sum[LO-1:0]};
  assign cout   = (op == OP_ADD) ? c_out : ~c_out;
  assign ovf    = (a[WIDTH-1] == bx[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/addsub_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or after ptr,
// with wrap-around. It produces both a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  int   pos;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(ptr) + k) % NREQ;
      if (!found && req[pos]) begin
        gnt[pos] = 1'b1;
        idx      = IDW'(pos);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/addsub_rr_scheduler.sv
// Shares one add/sub datapath among NREQ requesters: round-robin grant, operand
// capture, fixed EXEC_CY-cycle execution, then a held, tagged response.
module addsub_rr_scheduler
  import addsub_rr_scheduler_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int EXEC_CY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_op,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_result,
  output logic                  resp_cout,
  output logic                  resp_ovf
);

  localparam int CW = (EXEC_CY > 1) ? $clog2(EXEC_CY) : 1;

  logic [1:0]       state;
  logic [IDW-1:0]   rr_ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_op;
  logic [IDW-1:0]   op_id;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gidx;
  logic [WIDTH-1:0] sum;
  logic             sum_cout;
  logic             sum_ovf;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gidx)
  );

  carry_select_adder_subtractor #(.WIDTH(WIDTH)) u_addsub (
    .a      (op_a),
    .b      (op_b),
    .op     (op_op),
    .result (sum),
    .cout   (sum_cout),
    .ovf    (sum_ovf)
  );

  // Grant is only offered while idle and out of reset, so a reset pulse silences it at once.
  assign req_ready  = (state == S_IDLE && rst_n) ? gnt : '0;
  assign resp_valid = (state == S_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      cnt         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_op       <= 1'b0;
      op_id       <= '0;
      resp_id     <= '0;
      resp_result <= '0;
      resp_cout   <= 1'b0;
      resp_ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            op_a   <= req_a[gidx*WIDTH +: WIDTH];
            op_b   <= req_b[gidx*WIDTH +: WIDTH];
            op_op  <= req_op[gidx];
            op_id  <= gidx;
            rr_ptr <= IDW'(wrap_next(int'(gidx), NREQ));
            cnt    <= '0;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt == CW'(EXEC_CY - 1)) begin
            resp_result <= sum;
            resp_cout   <= sum_cout;
            resp_ovf    <= sum_ovf;
            resp_id     <= op_id;
            cnt         <= '0;
            state       <= S_RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Directed bench for addsub_rr_scheduler: arithmetic results and flags, grant order,
// response backpressure and mid-operation reset, all against hand-computed values.
module tb_addsub_rr_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_op;
  logic         resp_valid;
  logic         resp_ready;
  logic [1:0]   resp_id;
  logic [31:0]  resp_result;
  logic         resp_cout;
  logic         resp_ovf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  addsub_rr_scheduler #(.WIDTH(32), .NREQ(4), .IDW(2), .EXEC_CY(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_cout   (resp_cout),
    .resp_ovf    (resp_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Bounded wait for resp_valid; an expired bound counts as a miscompare.
  task automatic wait_resp();
    int n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_vec++;
    if (resp_valid !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL resp_timeout: resp_valid=%b after %0d cycles, expected 1", resp_valid, n);
    end
  endtask

  // Single-requester transaction; operands are scrambled right after the handshake.
  task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic op,
                        output logic [3:0] g, output logic [31:0] r, output logic c,
                        output logic v, output logic [1:0] rid, output int lat);
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
    req_op[id]         = op;
    req_valid[id]      = 1'b1;
    #1;
    g = req_ready;
    @(posedge clk);
    #1;
    req_valid[id]      = 1'b0;
    req_a[id*32 +: 32] = ~a;
    req_b[id*32 +: 32] = ~b;
    req_op[id]         = ~op;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    r   = resp_result;
    c   = resp_cout;
    v   = resp_ovf;
    rid = resp_id;
    tick();
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = 4'hF;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 1'b1;
    tick();
    tick();
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    n_vec++; if (resp_id !== 2'd0) begin n_err++; $display("[TB] FAIL reset_resp_id: got %0d expected 0", resp_id); end
    n_vec++; if (resp_result !== 32'h0) begin n_err++; $display("[TB] FAIL reset_resp_result: got %h expected 0", resp_result); end
    n_vec++; if ({resp_cout, resp_ovf} !== 2'b00) begin n_err++; $display("[TB] FAIL reset_flags: got %b expected 00", {resp_cout, resp_ovf}); end
    req_valid = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add_sub();
    logic [3:0] g; logic [31:0] r; logic c, v; logic [1:0] rid; int lat;
    run_op(0, 32'd5, 32'd3, 1'b1, g, r, c, v, rid, lat);
    n_vec++; if (g !== 4'b0001) begin n_err++; $display("[TB] FAIL add_grant: got %b expected 0001", g); end
    n_vec++; if (r !== 32'd8) begin n_err++; $display("[TB] FAIL add_result: got %h expected 00000008", r); end
    n_vec++; if ({c, v} !== 2'b00) begin n_err++; $display("[TB] FAIL add_flags: got %b expected 00", {c, v}); end
    n_vec++; if (rid !== 2'd0) begin n_err++; $display("[TB] FAIL add_id: got %0d expected 0", rid); end
    n_vec++; if (lat !== 2) begin n_err++; $display("[TB] FAIL add_latency: got %0d expected 2", lat); end
    run_op(1, 32'd3, 32'd5, 1'b0, g, r, c, v, rid, lat);
    n_vec++; if (g !== 4'b0010) begin n_err++; $display("[TB] FAIL sub_grant: got %b expected 0010", g); end
    n_vec++; if (r !== 32'hFFFFFFFE) begin n_err++; $display("[TB] FAIL sub_result: got %h expected fffffffe", r); end
    n_vec++; if ({c, v} !== 2'b10) begin n_err++; $display("[TB] FAIL sub_flags: got %b expected 10", {c, v}); end
    n_vec++; if (rid !== 2'd1) begin n_err++; $display("[TB] FAIL sub_id: got %0d expected 1", rid); end
    n_vec++; if (lat !== 2) begin n_err++; $display("[TB] FAIL sub_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_overflow();
    logic [3:0] g; logic [31:0] r; logic c, v; logic [1:0] rid; int lat;
    run_op(2, 32'h7FFFFFFF, 32'd1, 1'b1, g, r, c, v, rid, lat);
    n_vec++; if (r !== 32'h80000000) begin n_err++; $display("[TB] FAIL ovf_add_result: got %h expected 80000000", r); end
    n_vec++; if ({c, v} !== 2'b01) begin n_err++; $display("[TB] FAIL ovf_add_flags: got %b expected 01", {c, v}); end
    n_vec++; if (rid !== 2'd2) begin n_err++; $display("[TB] FAIL ovf_add_id: got %0d expected 2", rid); end
    run_op(3, 32'h80000000, 32'd1, 1'b0, g, r, c, v, rid, lat);
    n_vec++; if (r !== 32'h7FFFFFFF) begin n_err++; $display("[TB] FAIL ovf_sub_result: got %h expected 7fffffff", r); end
    n_vec++; if ({c, v} !== 2'b01) begin n_err++; $display("[TB] FAIL ovf_sub_flags: got %b expected 01", {c, v}); end
    n_vec++; if (rid !== 2'd3) begin n_err++; $display("[TB] FAIL ovf_sub_id: got %0d expected 3", rid); end
    run_op(0, 32'hFFFFFFFF, 32'd1, 1'b1, g, r, c, v, rid, lat);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("[TB] FAIL carry_result: got %h expected 00000000", r); end
    n_vec++; if ({c, v} !== 2'b10) begin n_err++; $display("[TB] FAIL carry_flags: got %b expected 10", {c, v}); end
    run_op(1, 32'd7, 32'd7, 1'b0, g, r, c, v, rid, lat);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("[TB] FAIL equal_sub_result: got %h expected 00000000", r); end
    n_vec++; if ({c, v} !== 2'b00) begin n_err++; $display("[TB] FAIL equal_sub_flags: got %b expected 00", {c, v}); end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = 32'(i + 1);
      req_b[i*32 +: 32] = 32'd0;
    end
    req_op    = 4'hF;
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #1;
      eg = 4'(1 << (k % 4));
      n_vec++; if (req_ready !== eg) begin n_err++; $display("[TB] FAIL rr_grant_%0d: got %b expected %b", k, req_ready, eg); end
      tick();
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("[TB] FAIL rr_busy_%0d: got %b expected 0000", k, req_ready); end
      wait_resp();
      n_vec++; if (resp_id !== 2'(k % 4)) begin n_err++; $display("[TB] FAIL rr_id_%0d: got %0d expected %0d", k, resp_id, k % 4); end
      n_vec++; if (resp_result !== 32'(k % 4 + 1)) begin n_err++; $display("[TB] FAIL rr_result_%0d: got %h expected %h", k, resp_result, 32'(k % 4 + 1)); end
      tick();
    end
    req_valid = 4'b0100;
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("[TB] FAIL rr_only2_grant: got %b expected 0100", req_ready); end
    tick();
    wait_resp();
    tick();
    req_valid = 4'b1001;
    #1;
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("[TB] FAIL rr_3_before_0: got %b expected 1000", req_ready); end
    tick();
    wait_resp();
    n_vec++; if (resp_id !== 2'd3) begin n_err++; $display("[TB] FAIL rr_3_id: got %0d expected 3", resp_id); end
    tick();
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("[TB] FAIL rr_then_0: got %b expected 0001", req_ready); end
    tick();
    wait_resp();
    n_vec++; if (resp_id !== 2'd0) begin n_err++; $display("[TB] FAIL rr_0_id: got %0d expected 0", resp_id); end
    tick();
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    resp_ready       = 1'b0;
    req_a[31:0]      = 32'd10;
    req_b[31:0]      = 32'd4;
    req_op[0]        = 1'b0;
    req_valid        = 4'b0001;
    tick();
    req_a[63:32]     = 32'd20;
    req_b[63:32]     = 32'd22;
    req_op[1]        = 1'b1;
    req_valid        = 4'b0010;
    wait_resp();
    for (int k = 0; k < 5; k++) begin
      n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("[TB] FAIL bp_valid_%0d: got %b expected 1", k, resp_valid); end
      n_vec++; if ({resp_id, resp_result, resp_cout, resp_ovf} !== {2'd0, 32'd6, 1'b0, 1'b0})
        begin n_err++; $display("[TB] FAIL bp_hold_%0d: got id=%0d res=%h c=%b v=%b expected id=0 res=00000006 c=0 v=0", k, resp_id, resp_result, resp_cout, resp_ovf); end
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("[TB] FAIL bp_ready_%0d: got %b expected 0000", k, req_ready); end
      tick();
    end
    resp_ready = 1'b1;
    tick();
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL bp_release_valid: got %b expected 0", resp_valid); end
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("[TB] FAIL bp_next_grant: got %b expected 0010", req_ready); end
    tick();
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("[TB] FAIL bp_next_busy: got %b expected 0000", req_ready); end
    req_valid = '0;
    wait_resp();
    n_vec++; if (resp_result !== 32'd42 || resp_id !== 2'd1) begin n_err++; $display("[TB] FAIL bp_next_resp: got id=%0d res=%h expected id=1 res=0000002a", resp_id, resp_result); end
    tick();
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    req_a[63:32] = 32'd100;
    req_b[63:32] = 32'd1;
    req_op[1]    = 1'b0;
    req_valid    = 4'b0010;
    tick();
    req_a[31:0]  = 32'd7;
    req_b[31:0]  = 32'd8;
    req_op[0]    = 1'b1;
    req_valid    = 4'hF;
    rst_n        = 1'b0;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("[TB] FAIL rst_exec_ready: got %b expected 0000", req_ready); end
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_exec_valid: got %b expected 0", resp_valid); end
    tick();
    tick();
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_hold_valid: got %b expected 0", resp_valid); end
    rst_n = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("[TB] FAIL rst_first_grant: got %b expected 0001", req_ready); end
    tick();
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_no_stale: got %b expected 0", resp_valid); end
    req_valid = '0;
    wait_resp();
    n_vec++; if (resp_id !== 2'd0 || resp_result !== 32'd15) begin n_err++; $display("[TB] FAIL rst_after_resp: got id=%0d res=%h expected id=0 res=0000000f", resp_id, resp_result); end
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish well before", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_add_sub();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_reset_mid_exec();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
